onehot_pulse_decoder: RTL and testbench

//  Registered 3-to-8 decoder, the inverse of the 8-to-3 priority encoder.
//  - Accepts a binary code over a valid/ready handshake.
//  - Drives the matching one-hot select line for a fixed number of cycles,

---
 rtl/onehot_pulse_decoder_if.sv | 31 +++
 rtl/onehot_pulse_decoder.sv | 135 +++++++++++++
 tb/tb_onehot_pulse_decoder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_pulse_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_pulse_decoder_if
//  Description : Handshake and strobe bundle for the one-hot pulse decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface onehot_pulse_decoder_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
);
    logic             enable;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic [OUT_W-1:0] out_onehot;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output enable, clear, in_valid, in_code,
        input  in_ready, out_onehot, out_valid, busy, done
    );

    modport slave (
        input  enable, clear, in_valid, in_code,
        output in_ready, out_onehot, out_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/onehot_pulse_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_pulse_decoder
//  Description : Registered 3-to-8 decoder that drives a timed one-hot strobe
//                per accepted code, followed by a fixed idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_pulse_decoder #(
    parameter int IN_W        = 3,
    parameter int OUT_W       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    onehot_pulse_decoder_if.slave bus
);

    localparam int c_cnt_max = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 2) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_load  = (GAP_CYCLES > 0) ? c_cnt_w'(GAP_CYCLES - 1) : '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drive = 2'd1;
    localparam logic [1:0] c_st_gap   = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [OUT_W-1:0]   r_onehot;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;

    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [OUT_W-1:0]   w_onehot_nxt;
    logic               w_out_valid_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [OUT_W-1:0]   w_decoded;
    logic               w_ready;
    logic               w_accept;

    // Code c selects bit OUT_W-1-c, mirroring the companion priority encoder.
    for (genvar i = 0; i < OUT_W; i++) begin : g_decode
        assign w_decoded[i] = (bus.in_code == IN_W'(OUT_W - 1 - i));
    end

    assign w_ready  = (r_state == c_st_idle) && bus.enable && !bus.clear;
    assign w_accept = w_ready && bus.in_valid;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_onehot_nxt    = r_onehot;
        w_out_valid_nxt = r_out_valid;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt     = c_st_drive;
                    w_cnt_nxt       = c_hold_load;
                    w_onehot_nxt    = w_decoded;
                    w_out_valid_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_done_nxt      = (HOLD_CYCLES == 1);
                end
            end
            c_st_drive: begin
                if (r_cnt == '0) begin
                    w_onehot_nxt    = '0;
                    w_out_valid_nxt = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = c_st_gap;
                        w_cnt_nxt   = c_gap_load;
                    end else begin
                        w_state_nxt = c_st_idle;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_cnt_nxt  = r_cnt - c_cnt_one;
                    // done is registered, so raise it as the count reaches zero.
                    w_done_nxt = (r_cnt == c_cnt_one);
                end
            end
            c_st_gap: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_idle;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            default: begin
                w_state_nxt     = c_st_idle;
                w_cnt_nxt       = '0;
                w_onehot_nxt    = '0;
                w_out_valid_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    // clear aborts exactly like reset, truncating any strobe without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_onehot    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_onehot    <= w_onehot_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.out_onehot = r_onehot;
    assign bus.out_valid  = r_out_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_onehot_pulse_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onehot_pulse_decoder
//  Description : Self-checking bench for onehot_pulse_decoder (default and
//                HOLD_CYCLES=1/GAP_CYCLES=0 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_pulse_decoder;

    localparam int HOLD = 4;
    localparam int GAP  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    onehot_pulse_decoder_if #(.IN_W(3), .OUT_W(8)) bus_a ();
    onehot_pulse_decoder_if #(.IN_W(3), .OUT_W(8)) bus_b ();

    onehot_pulse_decoder #(.IN_W(3), .OUT_W(8), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    onehot_pulse_decoder #(.IN_W(3), .OUT_W(8), .HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Reference model for instance A: remembers the last accepted code and when.
    int cyc      = 0;
    bit have_acc = 1'b0;
    int acc_cyc  = 0;
    int acc_code = 0;

    function automatic int m_age();
        return cyc - acc_cyc;
    endfunction

    function automatic bit m_drive();
        return have_acc && (m_age() >= 1) && (m_age() <= HOLD);
    endfunction

    function automatic bit m_busy();
        return have_acc && (m_age() >= 1) && (m_age() <= HOLD + GAP);
    endfunction

    function automatic logic [7:0] m_onehot();
        logic [7:0] top;
        top = 8'h80;
        return m_drive() ? (top >> acc_code) : 8'h00;
    endfunction

    function automatic bit m_done();
        return m_drive() && (m_age() == HOLD);
    endfunction

    function automatic bit m_ready();
        return !m_busy() && bus_a.enable && !bus_a.clear;
    endfunction

    task automatic step();
        if (!rst_n || bus_a.clear) begin
            have_acc = 1'b0;
        end else if (bus_a.in_valid && m_ready()) begin
            have_acc = 1'b1;
            acc_cyc  = cyc;
            acc_code = int'(bus_a.in_code);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.enable = 1'b0; bus_a.clear = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_code = 3'd0;
        bus_b.enable = 1'b0; bus_b.clear = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_code = 3'd0;
        step();
        step();
        n_tests++; if (bus_a.out_onehot !== 8'h00) begin n_fail++; $display("FAIL reset_onehot got=%h want=00", bus_a.out_onehot); end
        n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", bus_a.out_valid); end
        n_tests++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus_a.busy); end
        n_tests++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", bus_a.done); end
        n_tests++; if (bus_b.out_onehot !== 8'h00 || bus_b.busy !== 1'b0) begin n_fail++; $display("FAIL reset_b got=%h/%b want=00/0", bus_b.out_onehot, bus_b.busy); end
        rst_n = 1'b1;
        bus_a.enable = 1'b1;
        step();
        n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", bus_a.in_ready); end
    endtask

    task automatic test_single();
        bus_a.in_code = 3'd5; bus_a.in_valid = 1'b1;
        #1;
        n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready0 got=%b want=1", bus_a.in_ready); end
        step();
        bus_a.in_valid = 1'b0;
        bus_a.in_code = 3'($urandom);
        for (int a = 1; a <= 6; a++) begin
            n_tests++; if (bus_a.out_onehot !== ((a <= 4) ? 8'h04 : 8'h00)) begin n_fail++; $display("FAIL single_onehot age=%0d got=%h want=%h", a, bus_a.out_onehot, (a <= 4) ? 8'h04 : 8'h00); end
            n_tests++; if (bus_a.done !== (a == 4)) begin n_fail++; $display("FAIL single_done age=%0d got=%b want=%b", a, bus_a.done, a == 4); end
            n_tests++; if (bus_a.busy !== (a <= 5)) begin n_fail++; $display("FAIL single_busy age=%0d got=%b want=%b", a, bus_a.busy, a <= 5); end
            n_tests++; if (bus_a.in_ready !== (a == 6)) begin n_fail++; $display("FAIL single_ready age=%0d got=%b want=%b", a, bus_a.in_ready, a == 6); end
            if (a < 6) step();
        end
    endtask

    task automatic test_back_to_back();
        int last;
        logic [7:0] top;
        bit got;
        top  = 8'h80;
        last = -1;
        bus_a.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus_a.in_code = 3'(k);
            got = 1'b0;
            for (int w = 0; w < 12 && !got; w++) begin
                #1;
                if (bus_a.in_ready === 1'b1) begin
                    got = 1'b1;
                    if (k > 0) begin
                        n_tests++; if (cyc - last != HOLD + GAP + 1) begin n_fail++; $display("FAIL b2b_spacing code=%0d got=%0d want=%0d", k, cyc - last, HOLD + GAP + 1); end
                    end
                    last = cyc;
                end
                step();
                n_tests++; if (bus_a.out_onehot !== m_onehot() || bus_a.busy !== m_busy() || bus_a.done !== m_done()) begin n_fail++; $display("FAIL b2b_model cyc=%0d got=%h/%b/%b want=%h/%b/%b", cyc, bus_a.out_onehot, bus_a.busy, bus_a.done, m_onehot(), m_busy(), m_done()); end
                n_tests++; if ($countones(bus_a.out_onehot) > 1) begin n_fail++; $display("FAIL b2b_onehot cyc=%0d got=%h want=one-hot", cyc, bus_a.out_onehot); end
                if (got) begin
                    n_tests++; if (bus_a.out_onehot !== (top >> k)) begin n_fail++; $display("FAIL b2b_decode code=%0d got=%h want=%h", k, bus_a.out_onehot, top >> k); end
                end
            end
            if (!got) begin n_tests++; n_fail++; $display("FAIL b2b_timeout code=%0d got=no-accept want=accept", k); end
        end
        bus_a.in_valid = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_clear();
        bit saw_done;
        saw_done = 1'b0;
        bus_a.in_code = 3'd0; bus_a.in_valid = 1'b1;
        #1;
        step();
        bus_a.in_valid = 1'b0;
        n_tests++; if (bus_a.out_onehot !== 8'h80) begin n_fail++; $display("FAIL clear_drive1 got=%h want=80", bus_a.out_onehot); end
        step();
        n_tests++; if (bus_a.out_onehot !== 8'h80) begin n_fail++; $display("FAIL clear_drive2 got=%h want=80", bus_a.out_onehot); end
        bus_a.clear = 1'b1;
        #1;
        n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready_low got=%b want=0", bus_a.in_ready); end
        bus_a.in_valid = 1'b1;
        step();
        bus_a.clear = 1'b0; bus_a.in_valid = 1'b0;
        #1;
        n_tests++; if (bus_a.out_onehot !== 8'h00 || bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_truncate got=%h/%b want=00/0", bus_a.out_onehot, bus_a.out_valid); end
        n_tests++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy got=%b want=0", bus_a.busy); end
        n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL clear_ready_back got=%b want=1", bus_a.in_ready); end
        for (int i = 0; i < 5; i++) begin
            if (bus_a.done === 1'b1) saw_done = 1'b1;
            step();
        end
        n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL clear_no_done got=%b want=0", saw_done); end
    endtask

    task automatic test_enable();
        bus_a.enable = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_code = 3'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL en_ready_low got=%b want=0", bus_a.in_ready); end
            step();
            n_tests++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL en_no_accept got=%b want=0", bus_a.busy); end
        end
        bus_a.enable = 1'b1; bus_a.in_code = 3'd2;
        #1;
        step();
        bus_a.enable = 1'b0;
        for (int a = 1; a <= 7; a++) begin
            n_tests++; if (bus_a.out_onehot !== ((a <= 4) ? 8'h20 : 8'h00)) begin n_fail++; $display("FAIL en_strobe age=%0d got=%h want=%h", a, bus_a.out_onehot, (a <= 4) ? 8'h20 : 8'h00); end
            n_tests++; if (bus_a.done !== (a == 4) || bus_a.busy !== (a <= 5)) begin n_fail++; $display("FAIL en_done_busy age=%0d got=%b/%b want=%b/%b", a, bus_a.done, bus_a.busy, a == 4, a <= 5); end
            n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL en_ready age=%0d got=%b want=0", a, bus_a.in_ready); end
            step();
        end
        bus_a.enable = 1'b1; bus_a.in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n          = ($urandom_range(0, 49) != 0);
            bus_a.enable   = ($urandom_range(0, 9) != 0);
            bus_a.clear    = ($urandom_range(0, 19) == 0);
            bus_a.in_valid = 1'($urandom_range(0, 1));
            bus_a.in_code  = 3'($urandom);
            #1;
            n_tests++; if (bus_a.in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, bus_a.in_ready, m_ready()); end
            step();
            n_tests++; if (bus_a.out_onehot !== m_onehot()) begin n_fail++; $display("FAIL rnd_onehot cyc=%0d got=%h want=%h", cyc, bus_a.out_onehot, m_onehot()); end
            n_tests++; if (bus_a.out_valid !== m_drive()) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, bus_a.out_valid, m_drive()); end
            n_tests++; if (bus_a.busy !== m_busy()) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, bus_a.busy, m_busy()); end
            n_tests++; if (bus_a.done !== m_done()) begin n_fail++; $display("FAIL rnd_done cyc=%0d got=%b want=%b", cyc, bus_a.done, m_done()); end
            n_tests++; if (bus_a.out_valid !== (|bus_a.out_onehot) || $countones(bus_a.out_onehot) > 1) begin n_fail++; $display("FAIL rnd_invariant cyc=%0d got=%h/%b want=one-hot/consistent", cyc, bus_a.out_onehot, bus_a.out_valid); end
        end
        rst_n = 1'b1; bus_a.clear = 1'b0; bus_a.enable = 1'b1; bus_a.in_valid = 1'b0;
        repeat (7) step();
    endtask

    task automatic test_short();
        logic [7:0] top;
        int code;
        top = 8'h80;
        bus_b.enable = 1'b1; bus_b.in_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            code = int'($urandom_range(0, 7));
            bus_b.in_code = 3'(code);
            #1;
            n_tests++; if (bus_b.in_ready !== 1'b1) begin n_fail++; $display("FAIL short_ready n=%0d got=%b want=1", n, bus_b.in_ready); end
            step();
            n_tests++; if (bus_b.out_onehot !== (top >> code)) begin n_fail++; $display("FAIL short_onehot code=%0d got=%h want=%h", code, bus_b.out_onehot, top >> code); end
            n_tests++; if (bus_b.done !== 1'b1 || bus_b.busy !== 1'b1 || bus_b.in_ready !== 1'b0) begin n_fail++; $display("FAIL short_drive got=%b/%b/%b want=1/1/0", bus_b.done, bus_b.busy, bus_b.in_ready); end
            step();
            n_tests++; if (bus_b.out_onehot !== 8'h00 || bus_b.done !== 1'b0 || bus_b.busy !== 1'b0) begin n_fail++; $display("FAIL short_idle got=%h/%b/%b want=00/0/0", bus_b.out_onehot, bus_b.done, bus_b.busy); end
        end
        bus_b.in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_clear();
        test_enable();
        test_random();
        test_short();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
